// File: rtl/btn_evt_pkg.sv
// Shared types and defaults for the button event scheduler.
// Optional auto-repeat is enabled with BTN_AUTOREPEAT_EN.
package btn_evt_pkg;

    localparam int N_BTN_DEF = 4;
    localparam int IDX_W_DEF = 2;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/button_event_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around, so the previous winner has lowest priority.
module rr_pick
    import btn_evt_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [N_BTN-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p,
                                                  input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_BTN) s = s - N_BTN;
        return IDX_W'(s);
    endfunction

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            if (!gnt_valid && req[wrap_idx(ptr, k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = wrap_idx(ptr, k);
            end
        end
    end

endmodule

// File: rtl/button_event_scheduler.sv
// Queues one pending event per button and presents them round-robin over valid/ready.
// Define BTN_AUTOREPEAT_EN to synthesise auto-repeat events for a held button.
module button_event_scheduler
    import btn_evt_pkg::*;
#(
    parameter int N_BTN         = N_BTN_DEF,
    parameter int IDX_W         = IDX_W_DEF,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int RPT_CNT_W     = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_BTN-1:0] press_pulse,
    input  logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_repeat,
    output logic [N_BTN-1:0] overrun,
    input  logic             overrun_clr
);

    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] overrun_q, overrun_d;
    logic             evt_valid_q, evt_valid_d;
    logic [IDX_W-1:0] evt_idx_q, evt_idx_d;
    logic             evt_repeat_q, evt_repeat_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N_BTN-1:0] req;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic             slot_free;
    logic             load;
    logic [N_BTN-1:0] load_mask;
    logic [N_BTN-1:0] inject_mask;
    logic [N_BTN-1:0] rpt_flag;

    // Requests are masked while disabled so a flushing cycle never loads.
    assign req       = en ? pending_q : '0;
    assign slot_free = !evt_valid_q || evt_ready;
    assign load      = slot_free && gnt_valid;
    assign load_mask = load ? (N_BTN'(1) << gnt_idx) : '0;

    rr_pick #(
        .N_BTN(N_BTN),
        .IDX_W(IDX_W)
    ) u_pick (
        .req      (req),
        .ptr      (rr_ptr_q),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    always_comb begin
        pending_d = (pending_q & ~load_mask) | press_pulse | inject_mask;
        if (!en) pending_d = '0;

        overrun_d = overrun_q;
        if (en) overrun_d = overrun_q | (press_pulse & pending_q & ~load_mask);
        if (overrun_clr) overrun_d = '0;

        evt_valid_d  = evt_valid_q;
        evt_idx_d    = evt_idx_q;
        evt_repeat_d = evt_repeat_q;
        rr_ptr_d     = rr_ptr_q;
        if (load) begin
            evt_valid_d  = 1'b1;
            evt_idx_d    = gnt_idx;
            evt_repeat_d = rpt_flag[gnt_idx];
            rr_ptr_d     = gnt_idx;
        end else if (slot_free) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            overrun_q    <= '0;
            evt_valid_q  <= 1'b0;
            evt_idx_q    <= '0;
            evt_repeat_q <= 1'b0;
            rr_ptr_q     <= IDX_W'(N_BTN - 1);
        end else begin
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            evt_valid_q  <= evt_valid_d;
            evt_idx_q    <= evt_idx_d;
            evt_repeat_q <= evt_repeat_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    rpt_state_e           state_q, state_d;
    logic [IDX_W-1:0]     hold_q, hold_d;
    logic [RPT_CNT_W-1:0] cnt_q, cnt_d;
    logic [RPT_CNT_W-1:0] cnt_lim;
    logic [N_BTN-1:0]     rpt_flag_q, rpt_flag_d;
    logic                 accept;

    // Only genuine presses (re)arm the repeat timer.
    assign accept   = evt_valid_q && evt_ready && !evt_repeat_q;
    assign cnt_lim  = (state_q == RPT_DELAY) ? RPT_CNT_W'(REPEAT_DELAY - 1)
                                             : RPT_CNT_W'(REPEAT_PERIOD - 1);
    assign rpt_flag = rpt_flag_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        inject_mask = '0;
        if (!en) begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            hold_d  = evt_idx_q;
            cnt_d   = '0;
            state_d = RPT_DELAY;
        end else if (state_q != RPT_IDLE) begin
            if (!btn_level[hold_q]) begin
                state_d = RPT_IDLE;
            end else if (cnt_q == cnt_lim) begin
                inject_mask[hold_q] = 1'b1;
                cnt_d               = '0;
                state_d             = RPT_REPEAT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Press outranks repeat: a real press always clears the repeat tag.
    always_comb begin
        rpt_flag_d = (rpt_flag_q & ~load_mask) | inject_mask;
        rpt_flag_d = rpt_flag_d & ~press_pulse;
        if (!en) rpt_flag_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RPT_IDLE;
            hold_q     <= '0;
            cnt_q      <= '0;
            rpt_flag_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            rpt_flag_q <= rpt_flag_d;
        end
    end
`else
    localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD + RPT_CNT_W;
    logic unused_btn_level;

    assign unused_btn_level = ^btn_level;
    assign inject_mask      = '0;
    assign rpt_flag         = '0;
`endif

    assign evt_valid  = evt_valid_q;
    assign evt_idx    = evt_idx_q;
    assign evt_repeat = evt_repeat_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed self-checking bench for button_event_scheduler.
// Auto-repeat steps run only when BTN_AUTOREPEAT_EN is defined.
module tb_button_event_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] press_pulse;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_idx;
    logic       evt_repeat;
    logic [3:0] overrun;
    logic       overrun_clr;

    int errors = 0;
    int checks = 0;
    int n;
    int seen;

    always #5 clk = ~clk;

    button_event_scheduler #(
        .N_BTN        (4),
        .IDX_W        (2),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(5),
        .RPT_CNT_W    (26)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .press_pulse(press_pulse),
        .btn_level  (btn_level),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_idx    (evt_idx),
        .evt_repeat (evt_repeat),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        en          = 1'b1;
        press_pulse = '0;
        btn_level   = '0;
        evt_ready   = 1'b1;
        overrun_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic press(input logic [3:0] p);
        press_pulse = p;
        tick();
        press_pulse = '0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!evt_valid && cnt < 60) begin
            tick();
            cnt++;
        end
        if (!evt_valid) cnt = -1;
    endtask

    initial begin
        do_reset();
        check("rst_valid", evt_valid, 0);
        check("rst_idx", evt_idx, 0);
        check("rst_repeat", evt_repeat, 0);
        check("rst_overrun", overrun, 0);

        // single press latency: pending at t+1, valid at t+2, one cycle
        press(4'b0010);
        check("t1_lat1", evt_valid, 0);
        tick();
        check("t1_valid", evt_valid, 1);
        check("t1_idx", evt_idx, 1);
        check("t1_repeat", evt_repeat, 0);
        tick();
        check("t1_once", evt_valid, 0);

        // round-robin bursts from reset pointer
        do_reset();
        press(4'b1011);
        tick();
        check("t2a_e0", {evt_valid, evt_idx}, {1'b1, 2'd0});
        tick();
        check("t2a_e1", {evt_valid, evt_idx}, {1'b1, 2'd1});
        tick();
        check("t2a_e2", {evt_valid, evt_idx}, {1'b1, 2'd3});
        tick();
        check("t2a_idle", evt_valid, 0);
        press(4'b1011);
        tick();
        check("t2b_e0", evt_idx, 0);
        tick();
        check("t2b_e1", evt_idx, 1);
        tick();
        check("t2b_e2", evt_idx, 3);
        tick();
        press(4'b0001);
        tick();
        check("t2c_ptr0", {evt_valid, evt_idx}, {1'b1, 2'd0});
        tick();
        press(4'b1011);
        tick();
        check("t2c_e0", evt_idx, 1);
        tick();
        check("t2c_e1", evt_idx, 3);
        tick();
        check("t2c_e2", evt_idx, 0);
        tick();
        check("t2c_idle", evt_valid, 0);

        // overrun: slot held by btn0, btn2 pressed twice while pending
        evt_ready = 1'b0;
        press(4'b0001);
        tick();
        press(4'b0100);
        repeat (4) tick();
        press(4'b0100);
        check("t3_ovr", overrun, 4'b0100);
        check("t3_hold", {evt_valid, evt_idx}, {1'b1, 2'd0});
        evt_ready = 1'b1;
        tick();
        check("t3_e2", {evt_valid, evt_idx}, {1'b1, 2'd2});
        tick();
        check("t3_merged", evt_valid, 0);
        check("t3_sticky", overrun, 4'b0100);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("t3_clr", overrun, 0);

        // press in the same cycle its pending bit is loaded
        press(4'b0010);
        press(4'b0010);
        check("t3b_e1", {evt_valid, evt_idx}, {1'b1, 2'd1});
        check("t3b_no_ovr", overrun, 0);
        tick();
        check("t3b_e1_again", {evt_valid, evt_idx}, {1'b1, 2'd1});
        tick();
        check("t3b_idle", evt_valid, 0);

        // output stable under back-pressure, then rr order 3 before 0
        evt_ready = 1'b0;
        press(4'b0010);
        tick();
        check("t4_load", {evt_valid, evt_idx}, {1'b1, 2'd1});
        press(4'b0001);
        check("t4_stable_a", evt_idx, 1);
        tick();
        press(4'b1000);
        check("t4_stable_b", {evt_valid, evt_idx}, {1'b1, 2'd1});
        evt_ready = 1'b1;
        tick();
        check("t4_e3", evt_idx, 3);
        tick();
        check("t4_e0", evt_idx, 0);
        tick();
        check("t4_idle", evt_valid, 0);

        // disable: slot drains, pending flushed, pulses ignored
        evt_ready = 1'b0;
        press(4'b0001);
        tick();
        press(4'b0110);
        en = 1'b0;
        tick();
        check("t5_slot_kept", {evt_valid, evt_idx}, {1'b1, 2'd0});
        press(4'b1000);
        evt_ready = 1'b1;
        tick();
        check("t5_drained", evt_valid, 0);
        tick();
        check("t5_flushed", evt_valid, 0);
        en = 1'b1;
        tick();
        tick();
        check("t5_ignored", evt_valid, 0);

        // clear wins over same-cycle overrun set
        evt_ready = 1'b0;
        press(4'b0010);
        tick();
        press(4'b0010);
        overrun_clr = 1'b1;
        press(4'b0010);
        overrun_clr = 1'b0;
        check("t5b_clr_wins", overrun, 0);
        evt_ready = 1'b1;
        tick();
        tick();

`ifdef BTN_AUTOREPEAT_EN
        // repeats inject at +20/+25/+30 after accept, visible one cycle later
        do_reset();
        btn_level = 4'b1000;
        press(4'b1000);
        tick();
        check("t6_press", {evt_valid, evt_idx, evt_repeat}, {1'b1, 2'd3, 1'b0});
        tick();
        wait_valid(n);
        check("t6_r1_gap", n, 21);
        check("t6_r1", {evt_idx, evt_repeat}, {2'd3, 1'b1});
        tick();
        wait_valid(n);
        check("t6_r2_gap", n, 4);
        check("t6_r2", {evt_idx, evt_repeat}, {2'd3, 1'b1});
        tick();
        wait_valid(n);
        check("t6_r3_gap", n, 4);
        btn_level = 4'b0000;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (evt_valid) seen++;
        end
        check("t6_released", seen, 0);

        // second press mid-hold moves tracking to btn1
        btn_level = 4'b1000;
        press(4'b1000);
        tick();
        tick();
        repeat (5) tick();
        btn_level = 4'b1010;
        press(4'b0010);
        tick();
        check("t6_press1", {evt_valid, evt_idx, evt_repeat}, {1'b1, 2'd1, 1'b0});
        tick();
        wait_valid(n);
        check("t6_trk_gap", n, 21);
        check("t6_trk", {evt_idx, evt_repeat}, {2'd1, 1'b1});
        btn_level = 4'b0000;
        tick();
        tick();
`else
        check("t6_rpt_tied", evt_repeat, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
